// File: rtl/alu_issue_ctrl_if.sv
// Bundle of issue-stage signals: instruction input, ALU drive/return, writeback result.
// master = surrounding pipeline/ALU/writeback side, slave = alu_issue_ctrl.
// Handshakes: INSTR_VALID/INSTR_READY upstream, RES_VALID/RES_READY downstream.
interface alu_issue_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int OPRN_WIDTH = 6,
    parameter int ADDR_WIDTH = 5
);
    logic [31:0]           INSTR;
    logic                  INSTR_VALID;
    logic                  INSTR_READY;
    logic [DATA_WIDTH-1:0] R1_DATA;
    logic [DATA_WIDTH-1:0] R2_DATA;
    logic [DATA_WIDTH-1:0] ALU_OP1;
    logic [DATA_WIDTH-1:0] ALU_OP2;
    logic [OPRN_WIDTH-1:0] ALU_OPRN;
    logic [DATA_WIDTH-1:0] ALU_OUT;
    logic                  ALU_ZERO;
    logic [DATA_WIDTH-1:0] RES_DATA;
    logic                  RES_ZERO;
    logic [ADDR_WIDTH-1:0] RES_ADDR;
    logic                  RES_VALID;
    logic                  RES_READY;
    logic                  ILLEGAL;

    modport slave (
        input  INSTR, INSTR_VALID, R1_DATA, R2_DATA, ALU_OUT, ALU_ZERO, RES_READY,
        output INSTR_READY, ALU_OP1, ALU_OP2, ALU_OPRN, RES_DATA, RES_ZERO,
               RES_ADDR, RES_VALID, ILLEGAL
    );

    modport master (
        output INSTR, INSTR_VALID, R1_DATA, R2_DATA, ALU_OUT, ALU_ZERO, RES_READY,
        input  INSTR_READY, ALU_OP1, ALU_OP2, ALU_OPRN, RES_DATA, RES_ZERO,
               RES_ADDR, RES_VALID, ILLEGAL
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue stage feeding a combinational ALU: decode, build operands, capture result.
// Latency: accept at edge N, ALU execute in cycle N+1, result valid from cycle N+2.
// Backpressure: holds the result until RES_READY; no new instruction accepted until then.
module alu_issue_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int OPRN_WIDTH = 6,
    parameter int ADDR_WIDTH = 5
) (
    input  logic          CLK,
    input  logic          RST,
    alu_issue_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [OPRN_WIDTH-1:0] OPRN_NOP = OPRN_WIDTH'(0);
    localparam logic [OPRN_WIDTH-1:0] OPRN_ADD = OPRN_WIDTH'(1);
    localparam logic [OPRN_WIDTH-1:0] OPRN_SUB = OPRN_WIDTH'(2);
    localparam logic [OPRN_WIDTH-1:0] OPRN_MUL = OPRN_WIDTH'(3);
    localparam logic [OPRN_WIDTH-1:0] OPRN_SRL = OPRN_WIDTH'(4);
    localparam logic [OPRN_WIDTH-1:0] OPRN_SLL = OPRN_WIDTH'(5);
    localparam logic [OPRN_WIDTH-1:0] OPRN_AND = OPRN_WIDTH'(6);
    localparam logic [OPRN_WIDTH-1:0] OPRN_OR  = OPRN_WIDTH'(7);
    localparam logic [OPRN_WIDTH-1:0] OPRN_NOR = OPRN_WIDTH'(8);
    localparam logic [OPRN_WIDTH-1:0] OPRN_SLT = OPRN_WIDTH'(9);

    state_t state;
    state_t next_state;

    // instruction fields
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic        unused_rs;

    logic [DATA_WIDTH-1:0] imm_sext;
    logic [DATA_WIDTH-1:0] imm_zext;
    logic [DATA_WIDTH-1:0] shamt_zext;

    // decode results for the word currently on the input
    logic                  dec_legal;
    logic [OPRN_WIDTH-1:0] dec_oprn;
    logic [DATA_WIDTH-1:0] dec_op1;
    logic [DATA_WIDTH-1:0] dec_op2;
    logic [ADDR_WIDTH-1:0] dec_addr;

    // FSM-derived handshake outputs
    logic instr_ready;
    logic res_valid;

    // registered datapath
    logic [DATA_WIDTH-1:0] op1_q;
    logic [DATA_WIDTH-1:0] op2_q;
    logic [OPRN_WIDTH-1:0] oprn_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] res_data_q;
    logic                  res_zero_q;
    logic                  illegal_q;

    assign opcode    = bus.INSTR[31:26];
    assign rt        = bus.INSTR[20:16];
    assign rd        = bus.INSTR[15:11];
    assign shamt     = bus.INSTR[10:6];
    assign funct     = bus.INSTR[5:0];
    assign imm       = bus.INSTR[15:0];
    // rs only selects R1_DATA upstream; this block never looks at it
    assign unused_rs = ^bus.INSTR[25:21];

    assign imm_sext   = {{(DATA_WIDTH-16){imm[15]}}, imm};
    assign imm_zext   = DATA_WIDTH'(imm);
    assign shamt_zext = DATA_WIDTH'(shamt);

    // Decode opcode/funct into ALU operation, operands and destination
    always_comb begin
        dec_legal = 1'b0;
        dec_oprn  = OPRN_NOP;
        dec_op1   = bus.R1_DATA;
        dec_op2   = bus.R2_DATA;
        dec_addr  = ADDR_WIDTH'(rd);
        if (opcode == 6'h00) begin
            dec_legal = 1'b1;
            case (funct)
                6'h20:   dec_oprn = OPRN_ADD;
                6'h22:   dec_oprn = OPRN_SUB;
                6'h2c:   dec_oprn = OPRN_MUL;
                6'h02: begin
                    dec_oprn = OPRN_SRL;
                    dec_op2  = shamt_zext;
                end
                6'h01: begin
                    dec_oprn = OPRN_SLL;
                    dec_op2  = shamt_zext;
                end
                6'h24:   dec_oprn = OPRN_AND;
                6'h25:   dec_oprn = OPRN_OR;
                6'h27:   dec_oprn = OPRN_NOR;
                6'h2a:   dec_oprn = OPRN_SLT;
                default: dec_legal = 1'b0;
            endcase
        end else begin
            dec_legal = 1'b1;
            dec_addr  = ADDR_WIDTH'(rt);
            case (opcode)
                6'h08: begin
                    dec_oprn = OPRN_ADD;
                    dec_op2  = imm_sext;
                end
                6'h1d: begin
                    dec_oprn = OPRN_MUL;
                    dec_op2  = imm_sext;
                end
                6'h0c: begin
                    dec_oprn = OPRN_AND;
                    dec_op2  = imm_zext;
                end
                6'h0d: begin
                    dec_oprn = OPRN_OR;
                    dec_op2  = imm_zext;
                end
                6'h0a: begin
                    dec_oprn = OPRN_SLT;
                    dec_op2  = imm_sext;
                end
                6'h0f: begin
                    // lui is performed as imm << 16 in the ALU shifter
                    dec_oprn = OPRN_SLL;
                    dec_op1  = imm_zext;
                    dec_op2  = DATA_WIDTH'(16);
                end
                default: dec_legal = 1'b0;
            endcase
        end
    end

    // State register
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        next_state  = state;
        instr_ready = 1'b0;
        res_valid   = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (bus.INSTR_VALID && dec_legal) begin
                    next_state = EXEC;
                end
            end
            EXEC: begin
                next_state = RESP;
            end
            RESP: begin
                res_valid = 1'b1;
                if (bus.RES_READY) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Operand latch on accept, result capture after the execute cycle
    always_ff @(posedge CLK) begin
        if (!RST) begin
            op1_q      <= '0;
            op2_q      <= '0;
            oprn_q     <= OPRN_NOP;
            addr_q     <= '0;
            res_data_q <= '0;
            res_zero_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            illegal_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.INSTR_VALID) begin
                        if (dec_legal) begin
                            op1_q  <= dec_op1;
                            op2_q  <= dec_op2;
                            oprn_q <= dec_oprn;
                            addr_q <= dec_addr;
                        end else begin
                            illegal_q <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    res_data_q <= bus.ALU_OUT;
                    res_zero_q <= bus.ALU_ZERO;
                    // ALU sees a no-op outside the execute cycle; operands keep their values
                    oprn_q     <= OPRN_NOP;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.INSTR_READY = instr_ready;
    assign bus.RES_VALID   = res_valid;
    assign bus.ALU_OP1     = op1_q;
    assign bus.ALU_OP2     = op2_q;
    assign bus.ALU_OPRN    = oprn_q;
    assign bus.RES_DATA    = res_data_q;
    assign bus.RES_ZERO    = res_zero_q;
    assign bus.RES_ADDR    = addr_q;
    assign bus.ILLEGAL     = illegal_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: random + directed instructions, scoreboard monitor.
// Includes a behavioural ALU driving ALU_OUT/ALU_ZERO from the DUT's operands.
// Reference model predicts operands and results straight from the instruction mnemonic.
module tb_alu_issue_ctrl;
    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    alu_issue_ctrl_if #(.DATA_WIDTH(32), .OPRN_WIDTH(6), .ADDR_WIDTH(5)) bus ();

    alu_issue_ctrl #(.DATA_WIDTH(32), .OPRN_WIDTH(6), .ADDR_WIDTH(5)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    typedef struct {
        logic        legal;
        logic [5:0]  oprn;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] data;
        logic        zero;
        logic [4:0]  addr;
        int          acc;
        bit          exec_seen;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    int   rr_mode = 1;   // 0 random, 1 hold low, 2 hold high

    always @(posedge CLK) cyc <= cyc + 1;

    // Behavioural ALU
    logic [31:0] alu_r;
    always_comb begin
        alu_r = 32'h0;
        case (bus.ALU_OPRN)
            6'd1: alu_r = bus.ALU_OP1 + bus.ALU_OP2;
            6'd2: alu_r = bus.ALU_OP1 - bus.ALU_OP2;
            6'd3: alu_r = bus.ALU_OP1 * bus.ALU_OP2;
            6'd4: alu_r = bus.ALU_OP1 >> bus.ALU_OP2;
            6'd5: alu_r = bus.ALU_OP1 << bus.ALU_OP2;
            6'd6: alu_r = bus.ALU_OP1 & bus.ALU_OP2;
            6'd7: alu_r = bus.ALU_OP1 | bus.ALU_OP2;
            6'd8: alu_r = ~(bus.ALU_OP1 | bus.ALU_OP2);
            6'd9: alu_r = ($signed(bus.ALU_OP1) < $signed(bus.ALU_OP2)) ? 32'd1 : 32'd0;
            default: alu_r = 32'h0;
        endcase
        bus.ALU_OUT  = alu_r;
        bus.ALU_ZERO = (alu_r == 32'h0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic fail_evt(input string name);
        total++;
        bad++;
        $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
    endtask

    // Reference model: what the instruction means, not how the RTL decodes it
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
        exp_t        e;
        logic [15:0] imm;
        logic [31:0] sx;
        logic [31:0] zx;
        logic [31:0] sh;
        imm = ins[15:0];
        sx  = {{16{imm[15]}}, imm};
        zx  = {16'h0, imm};
        sh  = {27'h0, ins[10:6]};
        e   = '{legal: 1'b1, oprn: 6'd0, op1: r1, op2: r2, data: 32'h0, zero: 1'b0,
                addr: ins[20:16], acc: 0, exec_seen: 1'b0};
        if (ins[31:26] == 6'h00) begin
            e.addr = ins[15:11];
            case (ins[5:0])
                6'h20: begin e.oprn = 1; e.data = r1 + r2; end
                6'h22: begin e.oprn = 2; e.data = r1 - r2; end
                6'h2c: begin e.oprn = 3; e.data = r1 * r2; end
                6'h02: begin e.oprn = 4; e.op2 = sh; e.data = r1 >> ins[10:6]; end
                6'h01: begin e.oprn = 5; e.op2 = sh; e.data = r1 << ins[10:6]; end
                6'h24: begin e.oprn = 6; e.data = r1 & r2; end
                6'h25: begin e.oprn = 7; e.data = r1 | r2; end
                6'h27: begin e.oprn = 8; e.data = ~(r1 | r2); end
                6'h2a: begin e.oprn = 9; e.data = ($signed(r1) < $signed(r2)) ? 32'd1 : 32'd0; end
                default: e.legal = 1'b0;
            endcase
        end else begin
            case (ins[31:26])
                6'h08: begin e.oprn = 1; e.op2 = sx; e.data = r1 + sx; end
                6'h1d: begin e.oprn = 3; e.op2 = sx; e.data = r1 * sx; end
                6'h0c: begin e.oprn = 6; e.op2 = zx; e.data = r1 & zx; end
                6'h0d: begin e.oprn = 7; e.op2 = zx; e.data = r1 | zx; end
                6'h0a: begin e.oprn = 9; e.op2 = sx; e.data = ($signed(r1) < $signed(sx)) ? 32'd1 : 32'd0; end
                6'h0f: begin e.oprn = 5; e.op1 = zx; e.op2 = 32'd16; e.data = {imm, 16'h0}; end
                default: e.legal = 1'b0;
            endcase
        end
        e.zero = (e.data == 32'h0);
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int          k;
        w = $urandom;
        k = $urandom_range(0, 16);
        case (k)
            0:  begin w[31:26] = 6'h00; w[5:0] = 6'h20; end
            1:  begin w[31:26] = 6'h00; w[5:0] = 6'h22; end
            2:  begin w[31:26] = 6'h00; w[5:0] = 6'h2c; end
            3:  begin w[31:26] = 6'h00; w[5:0] = 6'h02; end
            4:  begin w[31:26] = 6'h00; w[5:0] = 6'h01; end
            5:  begin w[31:26] = 6'h00; w[5:0] = 6'h24; end
            6:  begin w[31:26] = 6'h00; w[5:0] = 6'h25; end
            7:  begin w[31:26] = 6'h00; w[5:0] = 6'h27; end
            8:  begin w[31:26] = 6'h00; w[5:0] = 6'h2a; end
            9:  w[31:26] = 6'h08;
            10: w[31:26] = 6'h1d;
            11: w[31:26] = 6'h0c;
            12: w[31:26] = 6'h0d;
            13: w[31:26] = 6'h0a;
            14: w[31:26] = 6'h0f;
            15: w[31:26] = 6'h00;   // random funct, usually illegal
            default: ;              // fully random word
        endcase
        return w;
    endfunction

    // Drive one word from posedge+1; returns once accepted (or timed out)
    task automatic issue(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
        exp_t e;
        bit   rdy;
        bit   done;
        int   waited;
        waited = 0;
        done   = 1'b0;
        bus.INSTR       = ins;
        bus.R1_DATA     = r1;
        bus.R2_DATA     = r2;
        bus.INSTR_VALID = 1'b1;
        while (!done) begin
            rdy = bus.INSTR_READY;
            @(posedge CLK);
            #1;
            if (rdy) begin
                done = 1'b1;
                e = model(ins, r1, r2);
                e.acc = cyc;
                sbq.push_back(e);
            end else begin
                waited++;
                if (waited > 40) begin
                    fail_evt("accept_timeout");
                    done = 1'b1;
                end
            end
        end
        bus.INSTR_VALID = 1'b0;
    endtask

    // Writeback ready generator
    always @(posedge CLK) begin
        #1;
        case (rr_mode)
            0:       bus.RES_READY = ($urandom_range(0, 3) != 0);
            1:       bus.RES_READY = 1'b0;
            default: bus.RES_READY = 1'b1;
        endcase
    end

    // Monitor: compares DUT activity against the scoreboard front
    bit          hold = 1'b0;
    bit          prev_xfer = 1'b0;
    logic [31:0] hold_data;
    logic        hold_zero;
    always @(negedge CLK) begin
        if (mon_en) begin
            if (prev_xfer) chk("ready_after_xfer", 32'(bus.INSTR_READY), 32'd1);
            prev_xfer = 1'b0;
            if (bus.ALU_OPRN != 6'd0) begin
                if (sbq.size() == 0 || !sbq[0].legal || sbq[0].exec_seen) begin
                    fail_evt("exec_unexpected");
                end else begin
                    chk("exec_oprn", 32'(bus.ALU_OPRN), 32'(sbq[0].oprn));
                    chk("exec_op1", bus.ALU_OP1, sbq[0].op1);
                    chk("exec_op2", bus.ALU_OP2, sbq[0].op2);
                    chk("exec_cycle", 32'(cyc), 32'(sbq[0].acc));
                    sbq[0].exec_seen = 1'b1;
                end
            end
            if (bus.ILLEGAL) begin
                if (sbq.size() == 0 || sbq[0].legal) begin
                    fail_evt("illegal_unexpected");
                end else begin
                    chk("illegal_cycle", 32'(cyc), 32'(sbq[0].acc));
                    chk("illegal_ready", 32'(bus.INSTR_READY), 32'd1);
                    void'(sbq.pop_front());
                end
            end
            if (!bus.RES_VALID) begin
                hold = 1'b0;
            end else begin
                chk("busy_not_ready", 32'(bus.INSTR_READY), 32'd0);
                if (sbq.size() == 0 || !sbq[0].legal || !sbq[0].exec_seen) begin
                    fail_evt("res_valid_unexpected");
                end else begin
                    if (!hold) begin
                        chk("res_latency", 32'(cyc), 32'(sbq[0].acc + 1));
                    end else begin
                        chk("hold_data", bus.RES_DATA, hold_data);
                        chk("hold_zero", 32'(bus.RES_ZERO), 32'(hold_zero));
                    end
                    if (bus.RES_READY) begin
                        chk("res_data", bus.RES_DATA, sbq[0].data);
                        chk("res_zero", 32'(bus.RES_ZERO), 32'(sbq[0].zero));
                        chk("res_addr", 32'(bus.RES_ADDR), 32'(sbq[0].addr));
                        void'(sbq.pop_front());
                        hold = 1'b0;
                        prev_xfer = 1'b1;
                    end else begin
                        hold = 1'b1;
                        hold_data = bus.RES_DATA;
                        hold_zero = bus.RES_ZERO;
                    end
                end
            end
        end
    end

    initial begin
        int waited;
        logic [31:0] r1;
        logic [31:0] r2;
        bus.INSTR       = 32'h0;
        bus.INSTR_VALID = 1'b0;
        bus.R1_DATA     = 32'h0;
        bus.R2_DATA     = 32'h0;
        bus.RES_READY   = 1'b0;
        RST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_instr_ready", 32'(bus.INSTR_READY), 32'd1);
        chk("rst_res_valid", 32'(bus.RES_VALID), 32'd0);
        chk("rst_res_data", bus.RES_DATA, 32'h0);
        chk("rst_alu_oprn", 32'(bus.ALU_OPRN), 32'd0);
        chk("rst_alu_op1", bus.ALU_OP1, 32'h0);
        chk("rst_illegal", 32'(bus.ILLEGAL), 32'd0);
        RST = 1'b1;
        mon_en = 1'b1;
        rr_mode = 2;

        // directed cases
        issue({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 32'd10, 32'hFFFF_FFF1);  // add
        issue({6'h08, 5'd1, 5'd7, 16'hFFF1}, 32'd15, 32'h0);                   // addi -> zero
        issue({6'h0c, 5'd1, 5'd4, 16'h8001}, 32'hFFFF_FFFF, 32'h0);            // andi
        issue({6'h0f, 5'd0, 5'd5, 16'h1234}, 32'hDEAD_BEEF, 32'h0);            // lui
        issue({6'h00, 5'd1, 5'd0, 5'd9, 5'd4, 6'h01}, 32'd1, 32'h0);           // sll
        issue({6'h23, 26'h0}, 32'd5, 32'd6);                                   // illegal
        issue({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h3f}, 32'd5, 32'd6);           // bad funct

        // backpressure: result held 4+ cycles while a new word waits
        rr_mode = 1;
        issue({6'h00, 5'd1, 5'd2, 5'd6, 5'd0, 6'h22}, 32'd100, 32'd1);         // sub
        bus.INSTR = {6'h0d, 5'd1, 5'd8, 16'h00F0};
        bus.R1_DATA = 32'h0F00_0000;
        bus.INSTR_VALID = 1'b1;
        repeat (6) @(posedge CLK);
        #1;
        rr_mode = 2;
        issue({6'h0d, 5'd1, 5'd8, 16'h00F0}, 32'h0F00_0000, 32'h0);            // ori

        // random traffic
        rr_mode = 0;
        for (int i = 0; i < 300; i++) begin
            r1 = $urandom;
            if ($urandom_range(0, 3) == 0) r1 = $urandom_range(0, 8);
            r2 = ($urandom_range(0, 3) == 0) ? r1 : 32'($urandom);
            issue(rand_instr(), r1, r2);
            repeat ($urandom_range(0, 2)) begin
                @(posedge CLK);
                #1;
            end
        end

        // drain
        rr_mode = 2;
        waited = 0;
        while (sbq.size() != 0 && waited < 100) begin
            @(posedge CLK);
            #1;
            waited++;
        end
        if (sbq.size() != 0) fail_evt("drain_timeout");

        // reset while a result is waiting in RESP
        rr_mode = 1;
        issue({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h25}, 32'h00A0_0000, 32'h0000_000B); // or
        waited = 0;
        while (!bus.RES_VALID && waited < 20) begin
            @(posedge CLK);
            #1;
            waited++;
        end
        chk("pre_rst_res_valid", 32'(bus.RES_VALID), 32'd1);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        sbq.delete();
        chk("mid_rst_res_valid", 32'(bus.RES_VALID), 32'd0);
        chk("mid_rst_res_data", bus.RES_DATA, 32'h0);
        chk("mid_rst_res_addr", 32'(bus.RES_ADDR), 32'd0);
        chk("mid_rst_alu_oprn", 32'(bus.ALU_OPRN), 32'd0);
        chk("mid_rst_instr_ready", 32'(bus.INSTR_READY), 32'd1);
        RST = 1'b1;
        rr_mode = 2;
        issue({6'h1d, 5'd1, 5'd9, 16'hFFFE}, 32'd21, 32'h0);                   // muli
        waited = 0;
        while (sbq.size() != 0 && waited < 20) begin
            @(posedge CLK);
            #1;
            waited++;
        end
        if (sbq.size() != 0) fail_evt("post_rst_timeout");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
